// File: rtl/eth_frame_mailbox_wb.sv
// Wishbone B3 classic slave exposing a single-frame Ethernet mailbox (one TX, one RX buffer).
// Host-side byte streams replace the PHY so the SoC Ethernet port can be simulated or looped back.
module eth_frame_mailbox_wb #(
    parameter int unsigned BUF_AW = 9
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        int_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        tx_last_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_last_i,
    output logic        rx_ready_o
);
    localparam int unsigned DEPTH   = 1 << BUF_AW;
    localparam logic [11:0] CAP     = 12'(4 << BUF_AW);
    localparam logic [23:0] TX_BASE = 24'h001000;
    localparam logic [23:0] RX_BASE = 24'h002000;
    localparam logic [23:0] TX_END  = TX_BASE + {12'h000, CAP};
    localparam logic [23:0] RX_END  = RX_BASE + {12'h000, CAP};

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} tx_state_t;

    logic [31:0] r_tx_mem [DEPTH];
    logic [31:0] r_rx_mem [DEPTH];

    tx_state_t   r_tx_state, w_tx_next;
    logic [11:0] r_tx_len, r_tx_idx, r_rx_cnt, r_rx_len;
    logic [31:0] r_tx_word;
    logic        r_rx_ie, r_tx_ie, r_tx_done, r_rx_ready, r_rx_ovf, r_int;

    logic [23:0]       w_adr;
    logic [BUF_AW-1:0] w_widx;
    logic [1:0]        w_rsel, w_tx_lane, w_rx_lane;
    logic              w_req, w_reg_hit, w_tx_hit, w_rx_hit, w_start_bad, w_bad, w_ok;
    logic              w_wr_ctrl, w_wr_status, w_wr_txlen, w_wr_rxack, w_tx_start;
    logic              w_tx_busy, w_tx_hs, w_tx_last, w_tx_fin;
    logic              w_rx_acc, w_rx_store, w_rx_drop;
    logic [31:0]       w_status;
    logic              w_unused;

    assign w_adr     = wb_adr_i[23:0];
    assign w_widx    = w_adr[BUF_AW+1:2];
    assign w_rsel    = w_adr[3:2];
    assign w_unused  = ^wb_adr_i[31:24];

    assign w_req     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign w_reg_hit = (w_adr[23:4] == '0);
    assign w_tx_hit  = (w_adr >= TX_BASE) && (w_adr < TX_END);
    assign w_rx_hit  = (w_adr >= RX_BASE) && (w_adr < RX_END);

    assign w_tx_busy   = (r_tx_state != S_IDLE);
    assign w_start_bad = w_tx_busy | (r_tx_len == '0) | (r_tx_len > CAP);
    assign w_bad = w_req & (~(w_reg_hit | w_tx_hit | w_rx_hit) |
                            (w_reg_hit & wb_we_i & (w_rsel == 2'd0) & wb_dat_i[0] & w_start_bad));
    assign w_ok  = w_req & ~w_bad;

    assign w_wr_ctrl   = w_ok & wb_we_i & w_reg_hit & (w_rsel == 2'd0);
    assign w_wr_status = w_ok & wb_we_i & w_reg_hit & (w_rsel == 2'd1);
    assign w_wr_txlen  = w_ok & wb_we_i & w_reg_hit & (w_rsel == 2'd2);
    assign w_wr_rxack  = w_ok & wb_we_i & w_reg_hit & (w_rsel == 2'd3);
    assign w_tx_start  = w_wr_ctrl & wb_dat_i[0];

    assign w_tx_hs   = tx_valid_o & tx_ready_i;
    assign w_tx_last = (r_tx_idx == r_tx_len - 12'd1);
    assign w_tx_fin  = w_tx_hs & w_tx_last;
    assign w_tx_lane = 2'd3 - r_tx_idx[1:0];

    // RX_ACK restarts the frame, so a byte arriving in that same cycle is dropped
    assign w_rx_acc   = rx_valid_i & ~r_rx_ready & ~w_wr_rxack;
    assign w_rx_store = w_rx_acc & (r_rx_cnt < CAP);
    assign w_rx_drop  = w_rx_acc & ~(r_rx_cnt < CAP);
    assign w_rx_lane  = 2'd3 - r_rx_cnt[1:0];

    assign w_status   = {4'h0, r_rx_len, 12'h000, r_tx_done, r_rx_ovf, r_rx_ready, w_tx_busy};
    assign rx_ready_o = ~r_rx_ready;
    assign int_o      = r_int;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) r_tx_state <= S_IDLE;
        else            r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            S_IDLE:  if (w_tx_start) w_tx_next = S_FETCH;
            S_FETCH: w_tx_next = S_SEND;
            S_SEND: begin
                if (w_tx_fin)                               w_tx_next = S_IDLE;
                else if (w_tx_hs && r_tx_idx[1:0] == 2'd3)  w_tx_next = S_FETCH;
            end
            default: w_tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_valid_o = 1'b0;
        tx_last_o  = 1'b0;
        tx_data_o  = '0;
        if (r_tx_state == S_SEND) begin
            tx_valid_o = 1'b1;
            tx_last_o  = w_tx_last;
            tx_data_o  = r_tx_word[{w_tx_lane, 3'b000} +: 8];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_tx_idx  <= '0;
            r_tx_word <= '0;
        end else begin
            if (w_tx_start)   r_tx_idx <= '0;
            else if (w_tx_hs) r_tx_idx <= r_tx_idx + 12'd1;
            if (r_tx_state == S_FETCH) r_tx_word <= r_tx_mem[r_tx_idx[BUF_AW+1:2]];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= w_ok;
            wb_err_o <= w_bad;
            if (w_ok && !wb_we_i) begin
                if (w_tx_hit)      wb_dat_o <= r_tx_mem[w_widx];
                else if (w_rx_hit) wb_dat_o <= r_rx_mem[w_widx];
                else begin
                    case (w_rsel)
                        2'd0:    wb_dat_o <= {29'h0, r_tx_ie, r_rx_ie, 1'b0};
                        2'd1:    wb_dat_o <= w_status;
                        2'd2:    wb_dat_o <= {20'h0, r_tx_len};
                        default: wb_dat_o <= '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_rx_ie    <= 1'b0;
            r_tx_ie    <= 1'b0;
            r_tx_len   <= '0;
            r_tx_done  <= 1'b0;
            r_rx_ovf   <= 1'b0;
            r_rx_ready <= 1'b0;
            r_rx_len   <= '0;
            r_rx_cnt   <= '0;
            r_int      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_rx_ie <= wb_dat_i[1];
                r_tx_ie <= wb_dat_i[2];
            end
            if (w_wr_txlen) r_tx_len <= wb_dat_i[11:0];
            // hardware set events win over a simultaneous W1C
            if (w_tx_fin)                                      r_tx_done <= 1'b1;
            else if (w_tx_start || (w_wr_status && wb_dat_i[3])) r_tx_done <= 1'b0;
            if (w_rx_drop)                         r_rx_ovf <= 1'b1;
            else if (w_wr_status && wb_dat_i[2])   r_rx_ovf <= 1'b0;
            if (w_wr_rxack) begin
                r_rx_ready <= 1'b0;
                r_rx_len   <= '0;
                r_rx_cnt   <= '0;
            end else if (w_rx_acc) begin
                if (w_rx_store) r_rx_cnt <= r_rx_cnt + 12'd1;
                if (rx_last_i) begin
                    r_rx_ready <= 1'b1;
                    r_rx_len   <= w_rx_store ? r_rx_cnt + 12'd1 : r_rx_cnt;
                end
            end
            r_int <= (r_rx_ie & r_rx_ready) | (r_tx_ie & r_tx_done);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_ok && wb_we_i && w_tx_hit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wb_sel_i[i]) r_tx_mem[w_widx][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_ok && wb_we_i && w_rx_hit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wb_sel_i[i]) r_rx_mem[w_widx][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
        end
        if (w_rx_store) r_rx_mem[r_rx_cnt[BUF_AW+1:2]][{w_rx_lane, 3'b000} +: 8] <= rx_data_i;
    end

endmodule

// File: tb/tb_eth_frame_mailbox_wb.sv
// Bench for eth_frame_mailbox_wb: bus tasks, RX byte driver and a TX byte scoreboard.
`timescale 1ns/1ps
module tb_eth_frame_mailbox_wb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr = '0, wdat = '0, wb_dat_o;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic        wb_ack_o, wb_err_o, int_o;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_last, tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0, rx_last = 1'b0, rx_ready;

    int tests_run = 0;
    int fails = 0;
    logic [8:0] exp_q [$];
    logic [8:0] obs_mem [0:255];
    int obs_n = 0;
    int rd_idx = 0;
    logic [31:0] rdat;
    logic rack, rerr, acc;

    eth_frame_mailbox_wb #(.BUF_AW(9)) dut (
        .wb_clk_i(clk), .wb_rstn_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(wb_dat_o),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o), .int_o(int_o), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
        .tx_last_o(tx_last), .tx_ready_i(tx_ready), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_last_i(rx_last), .rx_ready_o(rx_ready)
    );

    always #5 clk = ~clk;

    // TX monitor: records every byte that completes a handshake
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            obs_mem[obs_n % 256] = {tx_last, tx_data};
            obs_n = obs_n + 1;
        end
    end

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output logic k, output logic e);
        @(posedge clk); #1;
        adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        k = 1'b0; e = 1'b0; r = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) begin
                k = wb_ack_o; e = wb_err_o; r = wb_dat_o;
                break;
            end
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
    endtask

    task automatic rx_send(input logic [7:0] d, input logic l, input int budget, output logic a);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = d; rx_last = l; a = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_ready) begin a = 1'b1; break; end
        end
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_last = 1'b0;
    endtask

    task automatic tx_take_one();
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid) break;
        end
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    // scoreboard drain: pop n expected bytes and compare with what the monitor recorded
    task automatic drain_tx(input int n);
        logic [8:0] e, g;
        for (int k = 0; k < 300 && (obs_n - rd_idx) < n; k++) begin
            @(negedge clk); #1;
        end
        for (int j = 0; j < n; j++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_n - rd_idx <= 0) begin
                fails++;
                $display("FAIL tx_byte[%0d]: no byte seen, required last/data %h", j, e);
            end else begin
                g = obs_mem[rd_idx % 256];
                rd_idx++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL tx_byte[%0d]: got last/data %h, required %h", j, g, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({int_o, rx_ready, tx_valid, tx_last, wb_ack_o, wb_err_o} !== 6'b010000) begin
            fails++;
            $display("FAIL reset_outputs: int/rxr/txv/txl/ack/err=%b required 010000",
                     {int_o, rx_ready, tx_valid, tx_last, wb_ack_o, wb_err_o});
        end
        tests_run++;
        if (wb_dat_o !== 32'h0) begin fails++; $display("FAIL reset_dat_o: got %h required 0", wb_dat_o); end
        wb_xfer(1'b0, 32'h0000_0004, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if ({rack, rerr, rdat} !== {2'b10, 32'h0}) begin
            fails++; $display("FAIL reset_status: ack/err=%b%b data=%h required 10/0", rack, rerr, rdat);
        end
        wb_xfer(1'b0, 32'h0000_3000, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if ({rack, rerr} !== 2'b01) begin fails++; $display("FAIL bad_addr_3000: ack/err=%b%b required 01", rack, rerr); end
        wb_xfer(1'b0, 32'hAB00_0004, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if ({rack, rerr, rdat} !== {2'b10, 32'h0}) begin
            fails++; $display("FAIL high_adr_ignored: ack/err=%b%b data=%h required 10/0", rack, rerr, rdat);
        end
    endtask

    task automatic test_tx_basic();
        tx_ready = 1'b1;
        wb_xfer(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, rdat, rack, rerr);
        wb_xfer(1'b1, 32'h0008, 32'd4, 4'hF, rdat, rack, rerr);
        exp_q.push_back({1'b0, 8'hDE}); exp_q.push_back({1'b0, 8'hAD});
        exp_q.push_back({1'b0, 8'hBE}); exp_q.push_back({1'b1, 8'hEF});
        wb_xfer(1'b1, 32'h0000, 32'h5, 4'hF, rdat, rack, rerr);
        tests_run++;
        if ({rack, rerr} !== 2'b10) begin fails++; $display("FAIL tx_start_ack: ack/err=%b%b required 10", rack, rerr); end
        drain_tx(4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (int_o !== 1'b1) begin fails++; $display("FAIL tx_done_int: int_o=%b required 1", int_o); end
        wb_xfer(1'b0, 32'h0004, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'h0000_0008) begin fails++; $display("FAIL tx_done_status: got %h required 00000008", rdat); end
        wb_xfer(1'b1, 32'h0004, 32'h8, 4'hF, rdat, rack, rerr);
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (int_o !== 1'b0) begin fails++; $display("FAIL tx_done_w1c_int: int_o=%b required 0", int_o); end
        wb_xfer(1'b0, 32'h0004, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'h0) begin fails++; $display("FAIL tx_done_w1c: status %h required 00000000", rdat); end
    endtask

    task automatic test_rx_basic();
        wb_xfer(1'b1, 32'h0000, 32'h6, 4'hF, rdat, rack, rerr);
        for (int i = 1; i <= 5; i++) rx_send(8'(i), i == 5, 10, acc);
        wb_xfer(1'b0, 32'h0004, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'h0005_0002) begin fails++; $display("FAIL rx_status: got %h required 00050002", rdat); end
        wb_xfer(1'b0, 32'h2000, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'h0102_0304) begin fails++; $display("FAIL rx_word0: got %h required 01020304", rdat); end
        @(negedge clk);
        tests_run++;
        if ({rx_ready, int_o} !== 2'b01) begin
            fails++; $display("FAIL rx_ready_int: rx_ready/int_o=%b%b required 01", rx_ready, int_o);
        end
        rx_send(8'hAA, 1'b1, 5, acc);
        tests_run++;
        if (acc !== 1'b0) begin fails++; $display("FAIL rx_backpressure: accepted=%b required 0", acc); end
        wb_xfer(1'b0, 32'h0004, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'h0005_0002) begin fails++; $display("FAIL rx_status_held: got %h required 00050002", rdat); end
    endtask

    task automatic test_backpressure();
        wb_xfer(1'b1, 32'h1000, 32'h1011_1213, 4'hF, rdat, rack, rerr);
        wb_xfer(1'b1, 32'h1004, 32'h1415_1617, 4'hF, rdat, rack, rerr);
        wb_xfer(1'b1, 32'h0008, 32'd6, 4'hF, rdat, rack, rerr);
        for (int i = 0; i < 6; i++) exp_q.push_back({i == 5, 8'(8'h10 + i)});
        tx_ready = 1'b0;
        wb_xfer(1'b1, 32'h0000, 32'h7, 4'hF, rdat, rack, rerr);
        tx_take_one();
        tx_take_one();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if ({tx_valid, tx_data} !== {1'b1, 8'h12}) begin
                fails++; $display("FAIL tx_hold[%0d]: valid/data=%b/%h required 1/12", c, tx_valid, tx_data);
            end
        end
        wb_xfer(1'b1, 32'h0000, 32'h7, 4'hF, rdat, rack, rerr);
        tests_run++;
        if ({rack, rerr} !== 2'b01) begin fails++; $display("FAIL start_while_busy: ack/err=%b%b required 01", rack, rerr); end
        wb_xfer(1'b0, 32'h0000, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'h6) begin fails++; $display("FAIL ctrl_after_err: got %h required 00000006", rdat); end
        tx_ready = 1'b1;
        drain_tx(6);
        repeat (4) @(posedge clk);
        wb_xfer(1'b0, 32'h0004, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if ((rdat & 32'h9) !== 32'h8) begin fails++; $display("FAIL bp_done: status %h, bits[3,0] required 10", rdat); end
        wb_xfer(1'b1, 32'h0004, 32'h8, 4'hF, rdat, rack, rerr);
    endtask

    task automatic test_len_errors();
        wb_xfer(1'b1, 32'h0008, 32'd0, 4'hF, rdat, rack, rerr);
        wb_xfer(1'b1, 32'h0000, 32'h1, 4'hF, rdat, rack, rerr);
        tests_run++;
        if ({rack, rerr} !== 2'b01) begin fails++; $display("FAIL start_len0: ack/err=%b%b required 01", rack, rerr); end
        wb_xfer(1'b1, 32'h0008, 32'h801, 4'hF, rdat, rack, rerr);
        wb_xfer(1'b1, 32'h0000, 32'h1, 4'hF, rdat, rack, rerr);
        tests_run++;
        if ({rack, rerr} !== 2'b01) begin fails++; $display("FAIL start_len_cap1: ack/err=%b%b required 01", rack, rerr); end
        wb_xfer(1'b0, 32'h0000, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'h6) begin fails++; $display("FAIL ctrl_kept: got %h required 00000006", rdat); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (tx_valid !== 1'b0 || obs_n != rd_idx) begin
            fails++; $display("FAIL no_tx_on_err: tx_valid=%b extra bytes=%0d required 0/0", tx_valid, obs_n - rd_idx);
        end
        wb_xfer(1'b0, 32'h0010, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if ({rack, rerr} !== 2'b01) begin fails++; $display("FAIL bad_addr_010: ack/err=%b%b required 01", rack, rerr); end
        wb_xfer(1'b1, 32'h1800, 32'h0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if ({rack, rerr} !== 2'b01) begin fails++; $display("FAIL bad_addr_1800: ack/err=%b%b required 01", rack, rerr); end
        wb_xfer(1'b1, 32'h17FC, 32'hCAFE_F00D, 4'hF, rdat, rack, rerr);
        wb_xfer(1'b0, 32'h17FC, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if ({rack, rerr, rdat} !== {2'b10, 32'hCAFE_F00D}) begin
            fails++; $display("FAIL tx_buf_top: ack/err=%b%b data=%h required 10/cafef00d", rack, rerr, rdat);
        end
    endtask

    task automatic test_sel();
        wb_xfer(1'b1, 32'h1004, 32'h1122_3344, 4'hF, rdat, rack, rerr);
        wb_xfer(1'b1, 32'h1004, 32'h0000_AB00, 4'b0010, rdat, rack, rerr);
        wb_xfer(1'b0, 32'h1004, '0, 4'h0, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'h1122_AB44) begin fails++; $display("FAIL byte_sel: got %h required 1122ab44", rdat); end
    endtask

    task automatic test_overflow();
        int nacc;
        wb_xfer(1'b1, 32'h000C, 32'h0, 4'hF, rdat, rack, rerr);
        wb_xfer(1'b0, 32'h0004, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if ({rx_ready, rdat} !== {1'b1, 32'h0}) begin
            fails++; $display("FAIL rx_ack_clear: rx_ready=%b status=%h required 1/00000000", rx_ready, rdat);
        end
        nacc = 0;
        for (int i = 0; i < 2051; i++) begin
            rx_send(8'(i), i == 2050, 10, acc);
            if (acc) nacc++;
        end
        tests_run++;
        if (nacc != 2051) begin fails++; $display("FAIL ovf_accept: accepted %0d required 2051", nacc); end
        wb_xfer(1'b0, 32'h0004, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'h0800_0006) begin fails++; $display("FAIL ovf_status: got %h required 08000006", rdat); end
        wb_xfer(1'b0, 32'h2000, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'h0001_0203) begin fails++; $display("FAIL ovf_first: got %h required 00010203", rdat); end
        wb_xfer(1'b0, 32'h27FC, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'hFCFD_FEFF) begin fails++; $display("FAIL ovf_last: got %h required fcfdfeff", rdat); end
        wb_xfer(1'b1, 32'h000C, 32'h0, 4'hF, rdat, rack, rerr);
        wb_xfer(1'b0, 32'h0004, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if ({rx_ready, rdat} !== {1'b1, 32'h4}) begin
            fails++; $display("FAIL ovf_rx_ack: rx_ready=%b status=%h required 1/00000004", rx_ready, rdat);
        end
        wb_xfer(1'b1, 32'h0004, 32'h4, 4'hF, rdat, rack, rerr);
        wb_xfer(1'b0, 32'h0004, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'h0) begin fails++; $display("FAIL ovf_w1c: status %h required 00000000", rdat); end
    endtask

    task automatic test_reset_midframe();
        tx_ready = 1'b0;
        wb_xfer(1'b1, 32'h0008, 32'h40, 4'hF, rdat, rack, rerr);
        wb_xfer(1'b1, 32'h0000, 32'h7, 4'hF, rdat, rack, rerr);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_valid) break;
        end
        tests_run++;
        if (tx_valid !== 1'b1) begin fails++; $display("FAIL midframe_valid: tx_valid=%b required 1", tx_valid); end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({tx_valid, int_o, rx_ready, wb_ack_o} !== 4'b0010) begin
            fails++; $display("FAIL async_reset: txv/int/rxr/ack=%b required 0010", {tx_valid, int_o, rx_ready, wb_ack_o});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        wb_xfer(1'b0, 32'h0004, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'h0) begin fails++; $display("FAIL post_reset_status: got %h required 00000000", rdat); end
        wb_xfer(1'b0, 32'h0008, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'h0) begin fails++; $display("FAIL post_reset_txlen: got %h required 00000000", rdat); end
        wb_xfer(1'b0, 32'h0000, '0, 4'hF, rdat, rack, rerr);
        tests_run++;
        if (rdat !== 32'h0) begin fails++; $display("FAIL post_reset_ctrl: got %h required 00000000", rdat); end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_rx_basic();
        test_backpressure();
        test_len_errors();
        test_sel();
        test_overflow();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
